matrix_entry: RTL and testbench
===============================

Name: matrix_entry

Overview:
- Downstream consumer of the keypad encoder's keycode/keystrobe pair.
- Turns keypresses into decimal matrix elements: up to two digits per element, one element at a time.
- Packs NUM_ELEM committed elements into a flat bus and presents them to the matrix arithmetic core through a valid/ack handshake.
- Exports the in-progress entry as BCD digits for the seven-segment drivers.

Parameters:
- NUM_ELEM, 4, number of elements per matrix (2x2 default); must be ≥2.
- IDX_W, $clog2(NUM_ELEM), width of the element index.

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-high reset.
- keycode  input  4  encoded key from the keypad encoder; 0-9 digit, 10 NEXT, 11 CLEAR, 12 BACK, 13-15 unused.
- keystrobe  input  1  level-high while a key is held (from encoder).
- matrix_out  output  8*NUM_ELEM  committed elements; element i at [8i+7:8i], range 0-99.
- matrix_valid  output  1  matrix complete, held until acknowledged.
- matrix_ack  input  1  consumer has taken matrix_out.
- cur_idx  output  IDX_W  index of the element being entered.
- bcd_tens  output  4  tens digit of the in-progress entry.
- bcd_ones  output  4  ones digit of the in-progress entry.
- digit_cnt  output  2  digits entered for the current element (0-2).

Behaviour:
- Reset is asynchronous and active-high. While reset is high, all registers clear:
  - matrix_out=0, matrix_valid=0, cur_idx=0, bcd_tens=0, bcd_ones=0, digit_cnt=0.
  - Internal strobe_q=0, state=ENTRY.
- Edge detect:
  - strobe_q registers keystrobe every clk.
  - key_evt = keystrobe & ~strobe_q.
  - keycode is sampled in the key_evt cycle.
  - The action's effect is visible on outputs one clock after that cycle.
  - Holding a key generates exactly one event; no auto-repeat.
- State ENTRY, on key_evt:
  - Digit d (0-9), digit_cnt<2: bcd_tens←bcd_ones, bcd_ones←d, digit_cnt+1.
  - Digit with digit_cnt==2: ignored (entry saturates at two digits).
  - NEXT:
    - Write element cur_idx ← bcd_tens*10+bcd_ones (8 bits). An empty entry commits 0.
    - Clear bcd_tens, bcd_ones and digit_cnt.
    - If cur_idx==NUM_ELEM-1: cur_idx←0, state←FULL, matrix_valid←1.
    - Otherwise cur_idx+1.
  - CLEAR: bcd_tens, bcd_ones and digit_cnt←0. Committed elements are untouched.
  - BACK: see Optional Feature.
  - Keycodes 13-15: ignored.
- State FULL:
  - matrix_valid stays 1 and matrix_out is stable; all key events are discarded.
  - matrix_ack==1: matrix_valid←0, state←ENTRY next clock.
  - matrix_out keeps its old contents until overwritten element by element.
  - A key_evt in the same cycle as ack is dropped; ack wins.
- matrix_ack in ENTRY: ignored.
- Reset mid-entry or while FULL: everything returns to the reset values; partial elements are lost.
- No combinational path from inputs to outputs.

Optional Feature:
- Macro: MATRIX_ENTRY_BACK_EN.
- Defined: BACK (keycode 12) in ENTRY with digit_cnt>0 does bcd_ones←bcd_tens, bcd_tens←0, digit_cnt−1. BACK with digit_cnt==0 is ignored.
- Undefined: keycode 12 is ignored like 13-15; no backspace logic is synthesised.

Test Plan:
- Reset, then keystrobe pulses with keycodes 4,2,NEXT → after the NEXT event, matrix_out[7:0]=42, cur_idx=1, digit_cnt=0, bcd_tens/ones=0.
- Enter 1,2,NEXT / 3,NEXT / NEXT / 9,9,NEXT → matrix_valid=1 one clock after the last event, matrix_out={99,0,3,12} (element3..0), cur_idx=0. With matrix_ack held 0 for 10 cycles, valid and data stay stable.
- Hold keystrobe high 20 cycles with keycode 7 → exactly one digit: bcd_ones=7, digit_cnt=1. Then keys 8 and 9 → tens=7, ones=8, digit_cnt=2; the 9 is ignored.
- FULL state, pulse keycode 5 coincident with matrix_ack → matrix_valid=0 next clock, state ENTRY, digit_cnt=0 (key dropped). A following key 5 → bcd_ones=5.
- Digits 3,6 then CLEAR → tens=ones=0, digit_cnt=0, cur_idx unchanged. With MATRIX_ENTRY_BACK_EN: digits 3,6 then BACK → ones=3, tens=0, digit_cnt=1. Without the macro: BACK leaves 3,6 unchanged.
- Assert reset asynchronously mid-entry (cur_idx=2, digit_cnt=1) between clock edges → all outputs 0 immediately, before the next clk edge.

Source files
------------

// File: rtl/matrix_entry.sv
// Keypad-driven matrix element entry: two-digit decimal elements packed into a
// flat bus with a valid/ack handoff. Define MATRIX_ENTRY_BACK_EN for backspace.
module matrix_entry #(
   parameter int NUM_ELEM = 4,
   parameter int IDX_W    = $clog2(NUM_ELEM)
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [3:0]            keycode,
   input  logic                  keystrobe,
   output logic [8*NUM_ELEM-1:0] matrix_out,
   output logic                  matrix_valid,
   input  logic                  matrix_ack,
   output logic [IDX_W-1:0]      cur_idx,
   output logic [3:0]            bcd_tens,
   output logic [3:0]            bcd_ones,
   output logic [1:0]            digit_cnt
);

   typedef enum logic {ENTRY, FULL} state_t;

   localparam logic [3:0] KEY_NEXT  = 4'd10;
   localparam logic [3:0] KEY_CLEAR = 4'd11;
`ifdef MATRIX_ENTRY_BACK_EN
   localparam logic [3:0] KEY_BACK  = 4'd12;
`endif

   state_t     state;
   logic       strobe_q;
   logic       key_evt;
   logic [7:0] entry_val;

   assign key_evt   = keystrobe & ~strobe_q;
   assign entry_val = ({4'd0, bcd_tens} * 8'd10) + {4'd0, bcd_ones};

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state        <= ENTRY;
         strobe_q     <= 1'b0;
         matrix_out   <= '0;
         matrix_valid <= 1'b0;
         cur_idx      <= '0;
         bcd_tens     <= '0;
         bcd_ones     <= '0;
         digit_cnt    <= '0;
      end else begin
         strobe_q <= keystrobe;
         case (state)
            ENTRY: begin
               if (key_evt) begin
                  if (keycode <= 4'd9) begin
                     // entry saturates at two digits
                     if (digit_cnt != 2'd2) begin
                        bcd_tens  <= bcd_ones;
                        bcd_ones  <= keycode;
                        digit_cnt <= digit_cnt + 2'd1;
                     end
                  end else begin
                     case (keycode)
                        KEY_NEXT: begin
                           for (int unsigned i = 0; i < NUM_ELEM; i++) begin
                              if (cur_idx == IDX_W'(i))
                                 matrix_out[8*i +: 8] <= entry_val;
                           end
                           bcd_tens  <= '0;
                           bcd_ones  <= '0;
                           digit_cnt <= '0;
                           if (cur_idx == IDX_W'(NUM_ELEM - 1)) begin
                              cur_idx      <= '0;
                              state        <= FULL;
                              matrix_valid <= 1'b1;
                           end else begin
                              cur_idx <= cur_idx + IDX_W'(1);
                           end
                        end
                        KEY_CLEAR: begin
                           bcd_tens  <= '0;
                           bcd_ones  <= '0;
                           digit_cnt <= '0;
                        end
`ifdef MATRIX_ENTRY_BACK_EN
                        KEY_BACK: begin
                           if (digit_cnt != 2'd0) begin
                              bcd_ones  <= bcd_tens;
                              bcd_tens  <= '0;
                              digit_cnt <= digit_cnt - 2'd1;
                           end
                        end
`endif
                        default: ;
                     endcase
                  end
               end
            end
            FULL: begin
               // key events are discarded here, including one coincident with ack
               if (matrix_ack) begin
                  matrix_valid <= 1'b0;
                  state        <= ENTRY;
               end
            end
            default: state <= ENTRY;
         endcase
      end
   end

endmodule

// File: tb/tb_matrix_entry.sv
// Self-checking bench for matrix_entry: directed scenarios plus random key
// traffic compared against a decimal-arithmetic reference model.
module tb_matrix_entry;

   localparam int NE = 4;
   localparam int IW = $clog2(NE);

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic [3:0]    keycode = '0;
   logic          keystrobe = 1'b0;
   logic          matrix_ack = 1'b0;
   logic [8*NE-1:0] matrix_out;
   logic          matrix_valid;
   logic [IW-1:0] cur_idx;
   logic [3:0]    bcd_tens;
   logic [3:0]    bcd_ones;
   logic [1:0]    digit_cnt;

   matrix_entry #(.NUM_ELEM(NE)) dut (
      .clk(clk), .reset(reset), .keycode(keycode), .keystrobe(keystrobe),
      .matrix_out(matrix_out), .matrix_valid(matrix_valid),
      .matrix_ack(matrix_ack), .cur_idx(cur_idx), .bcd_tens(bcd_tens),
      .bcd_ones(bcd_ones), .digit_cnt(digit_cnt)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_bad = 0;

   // reference model: the entry is a decimal number of at most two digits
   int elem[NE];
   int m_idx, m_val, m_ndig;
   bit m_full, m_prev;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < NE; i++) elem[i] = 0;
      m_idx = 0; m_val = 0; m_ndig = 0; m_full = 0; m_prev = 0;
   endtask

   task automatic model_step();
      bit evt;
      int k;
      evt = keystrobe && !m_prev;
      k = int'(keycode);
      m_prev = keystrobe;
      if (m_full) begin
         if (matrix_ack) m_full = 0;
      end else if (evt) begin
         if (k <= 9) begin
            if (m_ndig < 2) begin
               m_val = (m_val % 10) * 10 + k;
               m_ndig++;
            end
         end else if (k == 10) begin
            elem[m_idx] = m_val;
            m_val = 0; m_ndig = 0;
            if (m_idx == NE - 1) begin
               m_idx = 0;
               m_full = 1;
            end else begin
               m_idx++;
            end
         end else if (k == 11) begin
            m_val = 0; m_ndig = 0;
         end
`ifdef MATRIX_ENTRY_BACK_EN
         else if (k == 12 && m_ndig > 0) begin
            m_val = m_val / 10;
            m_ndig--;
         end
`endif
      end
   endtask

   task automatic check_all();
      logic [8*NE-1:0] exp_mat;
      for (int i = 0; i < NE; i++) exp_mat[8*i +: 8] = 8'(elem[i]);
      check("matrix_out", 64'(matrix_out), 64'(exp_mat));
      check("matrix_valid", 64'(matrix_valid), 64'(m_full));
      check("cur_idx", 64'(cur_idx), 64'(m_idx));
      check("bcd_tens", 64'(bcd_tens), 64'(m_val / 10));
      check("bcd_ones", 64'(bcd_ones), 64'(m_val % 10));
      check("digit_cnt", 64'(digit_cnt), 64'(m_ndig));
   endtask

   task automatic tick();
      if (reset) model_reset();
      else model_step();
      @(posedge clk);
      #1;
      check_all();
   endtask

   task automatic press(input logic [3:0] k, input int hold);
      keycode = k;
      keystrobe = 1'b1;
      repeat (hold) tick();
      keystrobe = 1'b0;
      tick();
   endtask

   task automatic do_reset();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      tick();
   endtask

   initial begin
      model_reset();
      @(posedge clk);
      #1;
      check_all();
      tick();
      reset = 1'b0;
      tick();

      // 4, 2, NEXT
      press(4'd4, 1); press(4'd2, 1); press(4'd10, 1);
      check("elem0_42", 64'(matrix_out[7:0]), 64'd42);
      check("idx_after_next", 64'(cur_idx), 64'd1);

      // full matrix: 12, 3, empty, 99
      do_reset();
      press(4'd1, 1); press(4'd2, 1); press(4'd10, 1);
      press(4'd3, 1); press(4'd10, 1);
      press(4'd10, 1);
      press(4'd9, 1); press(4'd9, 1);
      keycode = 4'd10; keystrobe = 1'b1;
      tick();
      check("valid_after_last", 64'(matrix_valid), 64'd1);
      keystrobe = 1'b0;
      for (int i = 0; i < 10; i++) begin
         tick();
         check("hold_valid", 64'(matrix_valid), 64'd1);
         check("hold_data", 64'(matrix_out), 64'h6300030C);
         check("hold_idx", 64'(cur_idx), 64'd0);
      end

      // key coincident with ack is dropped
      keycode = 4'd5; keystrobe = 1'b1; matrix_ack = 1'b1;
      tick();
      matrix_ack = 1'b0; keystrobe = 1'b0;
      check("ack_valid", 64'(matrix_valid), 64'd0);
      check("ack_drop", 64'(digit_cnt), 64'd0);
      tick();
      press(4'd5, 1);
      check("after_ack_key", 64'(bcd_ones), 64'd5);

      // held key yields one digit; third digit ignored
      do_reset();
      press(4'd7, 20);
      check("hold_once_ones", 64'(bcd_ones), 64'd7);
      check("hold_once_cnt", 64'(digit_cnt), 64'd1);
      press(4'd8, 1); press(4'd9, 2);
      check("sat_tens", 64'(bcd_tens), 64'd7);
      check("sat_ones", 64'(bcd_ones), 64'd8);
      check("sat_cnt", 64'(digit_cnt), 64'd2);

      // CLEAR and BACK
      do_reset();
      press(4'd1, 1); press(4'd10, 1);
      press(4'd3, 1); press(4'd6, 1); press(4'd11, 1);
      check("clear_cnt", 64'(digit_cnt), 64'd0);
      check("clear_idx", 64'(cur_idx), 64'd1);
      press(4'd3, 1); press(4'd6, 1); press(4'd12, 1);
`ifdef MATRIX_ENTRY_BACK_EN
      check("back_ones", 64'(bcd_ones), 64'd3);
      check("back_tens", 64'(bcd_tens), 64'd0);
      check("back_cnt", 64'(digit_cnt), 64'd1);
`else
      check("back_ones", 64'(bcd_ones), 64'd6);
      check("back_tens", 64'(bcd_tens), 64'd3);
      check("back_cnt", 64'(digit_cnt), 64'd2);
`endif

      // asynchronous reset mid-entry
      do_reset();
      press(4'd1, 1); press(4'd10, 1); press(4'd2, 1); press(4'd10, 1);
      press(4'd4, 1);
      check("pre_rst_idx", 64'(cur_idx), 64'd2);
      #2;
      reset = 1'b1;
      #1;
      model_reset();
      check_all();
      check("async_out", 64'(matrix_out), 64'd0);
      check("async_cnt", 64'(digit_cnt), 64'd0);
      tick();
      reset = 1'b0;
      tick();

      // random traffic
      for (int n = 0; n < 600; n++) begin
         int r;
         int hold;
         r = int'($urandom_range(0, 19));
         keycode = (r < 10) ? 4'(r) : (r < 15) ? 4'd10 : 4'($urandom_range(11, 15));
         keystrobe = 1'b1;
         hold = int'($urandom_range(1, 4));
         for (int h = 0; h < hold; h++) begin
            matrix_ack = ($urandom_range(0, 3) == 0);
            tick();
         end
         keystrobe = 1'b0;
         hold = int'($urandom_range(1, 3));
         for (int h = 0; h < hold; h++) begin
            matrix_ack = ($urandom_range(0, 3) == 0);
            tick();
         end
      end
      matrix_ack = 1'b0;

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
